// File: rtl/syscall_pkg.sv
// Shared opcode constants, FSM state encoding and display widths for the
// syscall I/O unit.
package syscall_pkg;

  localparam int OP_W   = 6;
  localparam int SEG_W  = 7;
  localparam int WORD_W = 32;
  localparam int SW_W   = 16;

  localparam logic [OP_W-1:0] SYSCALL_IN  = 6'b110011;
  localparam logic [OP_W-1:0] SYSCALL_OUT = 6'b110111;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    WAIT_PRESS   = 2'd2,
    COMMIT       = 2'd3
  } state_t;

endpackage

// File: rtl/syscall_io_unit_if.sv
// CPU-side bus of the syscall I/O unit: opcode/operand from the core,
// stall and writeback value back to it.
interface syscall_io_unit_if;
  import syscall_pkg::*;

  logic [OP_W-1:0]   op;
  logic [WORD_W-1:0] reg_value;
  logic              stall;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;

  modport master (output op, reg_value, input stall, in_data, in_valid);
  modport slave  (input op, reg_value, output stall, in_data, in_valid);

endinterface

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order gfedcba.
module hex_to_7seg
  import syscall_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/syscall_io_unit.sv
// Syscall console: SYSCALL_IN stalls the core until a debounced button press
// captures the switches; SYSCALL_OUT latches a value onto four hex digits.
module syscall_io_unit
  import syscall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  syscall_io_unit_if.slave  bus,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_confirm,
  output logic [SEG_W-1:0]  hex0,
  output logic [SEG_W-1:0]  hex1,
  output logic [SEG_W-1:0]  hex2,
  output logic [SEG_W-1:0]  hex3
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]   sw_p0, sw_p1;
  logic              btn_p0, btn_p1;
  logic [CNT_W-1:0]  db_cnt;
  logic              db_level;
  logic              press;
  state_t            state;
  logic [WORD_W-1:0] in_data_q;
  logic              in_valid_q;
  logic              stall_c;
  logic [SW_W-1:0]   disp;
  logic              unused_reg_hi;

  // Stage p0/p1: two-flop synchronizers for the asynchronous user inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      btn_p0 <= btn_confirm;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: level follows btn_p1 only after DEBOUNCE_CYCLES straight disagreements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        db_cnt   <= '0;
        db_level <= btn_p1;
        press    <= btn_p1;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stall_c = 1'b0;
    unique case (state)
      IDLE:         stall_c = (bus.op == SYSCALL_IN);
      WAIT_RELEASE: stall_c = 1'b1;
      WAIT_PRESS:   stall_c = 1'b1;
      COMMIT:       stall_c = 1'b0;
      default:      stall_c = 1'b0;
    endcase
  end

  // Syscall FSM; in_valid is registered so it is high exactly in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_valid_q <= 1'b0;
          if (bus.op == SYSCALL_IN)
            state <= db_level ? WAIT_RELEASE : WAIT_PRESS;
        end
        WAIT_RELEASE: begin
          if (!db_level) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press) begin
            in_data_q  <= {{(WORD_W-SW_W){1'b0}}, sw_p1};
            in_valid_q <= 1'b1;
            state      <= COMMIT;
          end
        end
        COMMIT: begin
          in_valid_q <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          in_valid_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      disp <= '0;
    else if (bus.op == SYSCALL_OUT && !stall_c)
      disp <= bus.reg_value[SW_W-1:0];
  end

  // Only four digits exist, so the upper operand half is dropped
  assign unused_reg_hi = ^bus.reg_value[WORD_W-1:SW_W];

  assign bus.stall    = stall_c;
  assign bus.in_data  = in_data_q;
  assign bus.in_valid = in_valid_q;

  hex_to_7seg u_hex0 (.nibble(disp[3:0]),   .seg(hex0));
  hex_to_7seg u_hex1 (.nibble(disp[7:4]),   .seg(hex1));
  hex_to_7seg u_hex2 (.nibble(disp[11:8]),  .seg(hex2));
  hex_to_7seg u_hex3 (.nibble(disp[15:12]), .seg(hex3));

endmodule

// File: doc/syscall_io_unit.md
SYSCALL_IO_UNIT -- requirements
Module: syscall_io_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles before the debounced button level changes (5 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port op, input, 6, opcode of the current instruction.
REQ-005 SHALL have port reg_value, input, 32, rs register value to print.
REQ-006 SHALL have port sw, input, 16, user switches, asynchronous.
REQ-007 SHALL have port btn_confirm, input, 1, raw user confirm button, active-high, asynchronous.
REQ-008 SHALL have port stall, output, 1, freezes PC and register-file write while high.
REQ-009 SHALL have port in_data, output, 32, input value for register writeback.
REQ-010 SHALL have port in_valid, output, 1, writeback select for in_data, one cycle.
REQ-011 SHALL have port hex0..hex3, output, 7 each, active-low segments (gfedcba), hex0 = least significant nibble.

Function
REQ-012 SHALL decode SYSCALL_IN = 6'b110011 and SYSCALL_OUT = 6'b110111; all other opcodes ignored.
REQ-013 SHALL pass btn_confirm through a 2-flop synchronizer before any use.
REQ-014 SHALL change the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears whenever they match.
REQ-015 SHALL generate a one-cycle press event on each debounced 0->1 transition.
REQ-016 SHALL implement FSM states IDLE, WAIT_RELEASE, WAIT_PRESS, COMMIT.
REQ-017 IDLE, op = SYSCALL_IN: go to WAIT_RELEASE if the debounced level is 1, else WAIT_PRESS; otherwise stay in IDLE.
REQ-018 WAIT_RELEASE: go to WAIT_PRESS when the debounced level is 0.
REQ-019 WAIT_PRESS: on a press event, capture {16'b0, synchronized sw} into in_data and go to COMMIT.
REQ-020 COMMIT: go to IDLE unconditionally after one cycle.
REQ-021 stall SHALL be combinational: 1 in WAIT_RELEASE and WAIT_PRESS, 1 in IDLE when op = SYSCALL_IN, 0 otherwise (including COMMIT).
REQ-022 in_valid SHALL be 1 only in COMMIT.
REQ-023 in_data SHALL hold its value until the next capture.
REQ-024 sw SHALL pass through a 2-flop synchronizer; capture uses the synchronized value at the press-event edge.
REQ-025 On a rising edge with op = SYSCALL_OUT and stall = 0, the display register SHALL load reg_value[15:0]; reg_value[31:16] are discarded.
REQ-026 hex0..hex3 SHALL be combinational decodes of the display register nibbles, covering 0-F.
REQ-027 Button activity outside WAIT_PRESS SHALL update only the debouncer, with no capture.
REQ-028 Press-event latency: a raw press stable from cycle t SHALL give COMMIT at cycle t+2+DEBOUNCE_CYCLES+1, plus or minus one cycle.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, display register 0 (all hexN = 7'b1000000), in_data 0, in_valid 0, synchronizers 0, debounce counter 0, debounced level 0.
REQ-030 Reset during WAIT_PRESS/WAIT_RELEASE SHALL abort the syscall with no capture; after release, stall follows REQ-021 from IDLE.

Structure
REQ-031 Package syscall_pkg SHALL hold the SYSCALL_IN/SYSCALL_OUT opcode constants, the FSM state type, and the segment width constant.
REQ-032 Sub-module hex_to_7seg (4-bit in, 7-bit active-low out) SHALL be instantiated four times.

Verification (bench sets DEBOUNCE_CYCLES = 4)
REQ-033 Reset, idle op = 0: stall 0, in_valid 0, hex0..3 = 7'b1000000.
REQ-034 op = SYSCALL_OUT, reg_value = 32'hDEAD_1A2F: next cycle hex3..hex0 show 1,A,2,F; stall stays 0.
REQ-035 op held at SYSCALL_IN, sw = 16'h00C3, clean press: stall 1 until COMMIT; in_valid pulses once; in_data = 32'h0000_00C3.
REQ-036 Button bouncing 1-3 cycle pulses for 20 cycles, then stable high: exactly one COMMIT, only after the stable window.
REQ-037 Button already held at SYSCALL_IN entry: FSM enters WAIT_RELEASE; release then re-press; one capture only.
REQ-038 rst_n low mid-WAIT_PRESS: in_valid never asserts, in_data stays 0, state returns to IDLE.
